// File: rtl/cpu_mem_pkg.sv
// rtl/cpu_mem_pkg.sv - shared CPU/memory widths and read-return tag encoding
//
// Purpose: constants shared by the CPU pipeline, the memory port arbiter and
//          the memory macro wrapper.
// Contents: CPU_ADDR_W / CPU_DATA_W default widths, TAG_* read-return tags.
package cpu_mem_pkg;

   localparam int CPU_ADDR_W = 11;
   localparam int CPU_DATA_W = 32;

   // One bit per reader so a tag decodes to its valid strobe directly.
   localparam logic [1:0] TAG_NONE  = 2'b00;
   localparam logic [1:0] TAG_FETCH = 2'b01;
   localparam logic [1:0] TAG_LD    = 2'b10;

endpackage

// File: rtl/rd_tag_pipe.sv
// rtl/rd_tag_pipe.sv - shift register carrying read-return tags
//
// Purpose: delays the tag of each issued read by DEPTH cycles so it lines up
//          with the memory read data.
// Ports:
//   clk, resetn : clock, synchronous active-low clear of every stage
//   tag_i       : tag of the read issued this cycle (TAG_NONE when idle)
//   tag_o       : tag of the read whose data is on the memory bus now
module rd_tag_pipe
   import cpu_mem_pkg::*;
#(
   parameter int DEPTH = 1
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic [1:0] tag_i,
   output logic [1:0] tag_o
);

   logic [1:0] pipe_q [DEPTH];

   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) begin
            pipe_q[i] <= TAG_NONE;
         end
      end else begin
         pipe_q[0] <= tag_i;
         for (int i = 1; i < DEPTH; i++) begin
            pipe_q[i] <= pipe_q[i-1];
         end
      end
   end

   assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port SRAM arbiter for fetch, LOAD and STORE
//
// Purpose: grants one of three requesters per cycle onto a shared synchronous
//          SRAM. Priority is STORE > LOAD > fetch, except that a fetch denied
//          STARVE_LIMIT cycles in a row wins outright. Read data is returned
//          with a per-reader valid strobe RD_LATENCY cycles after issue.
// Ports:
//   clk, resetn                        : clock, synchronous active-low reset
//   fetch_req/adrs, fetch_gnt/rvalid   : instruction read port
//   ld_req/adrs, ld_gnt/rvalid         : LOAD read port
//   st_req/adrs/wdata, st_gnt          : STORE write port
//   mem_en/we/adrs/wdata, mem_rdata    : SRAM macro interface
//   rdata                              : read data broadcast (mem_rdata)
//   stall_fetch                        : fetch requesting but not granted
//   starve_cnt                         : consecutive denied fetch cycles
module mem_port_arbiter
   import cpu_mem_pkg::*;
#(
   parameter int ADDR_W       = CPU_ADDR_W,
   parameter int DATA_W       = CPU_DATA_W,
   parameter int STARVE_LIMIT = 4,
   parameter int RD_LATENCY   = 1
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_adrs,
   output logic              fetch_gnt,
   output logic              fetch_rvalid,
   input  logic              ld_req,
   input  logic [ADDR_W-1:0] ld_adrs,
   output logic              ld_gnt,
   output logic              ld_rvalid,
   input  logic              st_req,
   input  logic [ADDR_W-1:0] st_adrs,
   input  logic [DATA_W-1:0] st_wdata,
   output logic              st_gnt,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_adrs,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] rdata,
   output logic              stall_fetch,
   output logic [2:0]        starve_cnt
);

   localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

   logic [2:0] starve_cnt_q, starve_cnt_d;
   logic       fetch_win, ld_win, st_win;
   logic       fetch_starved;
   logic [1:0] tag_issue, tag_ret;

   assign fetch_starved = (starve_cnt_q == LIMIT);

   // Grants are forced low in reset so the macro sees no access.
   always_comb begin
      fetch_win = 1'b0;
      ld_win    = 1'b0;
      st_win    = 1'b0;
      if (resetn) begin
         if (fetch_req && fetch_starved) begin
            fetch_win = 1'b1;
         end else if (st_req) begin
            st_win = 1'b1;
         end else if (ld_req) begin
            ld_win = 1'b1;
         end else if (fetch_req) begin
            fetch_win = 1'b1;
         end
      end
   end

   assign fetch_gnt = fetch_win;
   assign ld_gnt    = ld_win;
   assign st_gnt    = st_win;
   assign mem_en    = fetch_win | ld_win | st_win;
   assign mem_we    = st_win;

   // Readers carry no write data, so wdata is only non-zero for a STORE.
   always_comb begin
      mem_adrs  = '0;
      mem_wdata = '0;
      if (st_win) begin
         mem_adrs  = st_adrs;
         mem_wdata = st_wdata;
      end else if (ld_win) begin
         mem_adrs = ld_adrs;
      end else if (fetch_win) begin
         mem_adrs = fetch_adrs;
      end
   end

   assign stall_fetch = fetch_req & ~fetch_win;

   always_comb begin
      if (!fetch_req || fetch_win) begin
         starve_cnt_d = '0;
      end else if (fetch_starved) begin
         starve_cnt_d = starve_cnt_q;
      end else begin
         starve_cnt_d = starve_cnt_q + 3'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         starve_cnt_q <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
      end
   end

   assign starve_cnt = starve_cnt_q;

   assign tag_issue = fetch_win ? TAG_FETCH : (ld_win ? TAG_LD : TAG_NONE);

   rd_tag_pipe #(
      .DEPTH (RD_LATENCY)
   ) u_rd_tag_pipe (
      .clk    (clk),
      .resetn (resetn),
      .tag_i  (tag_issue),
      .tag_o  (tag_ret)
   );

   // Tags are one-hot per reader, so the valids are single flop bits.
   assign fetch_rvalid = tag_ret[0];
   assign ld_rvalid    = tag_ret[1];
   assign rdata        = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
   import cpu_mem_pkg::*;

   localparam int AW    = 11;
   localparam int DW    = 32;
   localparam int LIMIT = 4;
   localparam int RDL   = 2;
   localparam int WORDS = 1 << AW;

   logic          clk = 1'b0;
   logic          resetn;
   logic          fetch_req, fetch_gnt, fetch_rvalid;
   logic [AW-1:0] fetch_adrs;
   logic          ld_req, ld_gnt, ld_rvalid;
   logic [AW-1:0] ld_adrs;
   logic          st_req, st_gnt;
   logic [AW-1:0] st_adrs;
   logic [DW-1:0] st_wdata;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_adrs;
   logic [DW-1:0] mem_wdata, mem_rdata, rdata;
   logic          stall_fetch;
   logic [2:0]    starve_cnt;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .ADDR_W       (AW),
      .DATA_W       (DW),
      .STARVE_LIMIT (LIMIT),
      .RD_LATENCY   (RDL)
   ) dut (
      .clk          (clk),
      .resetn       (resetn),
      .fetch_req    (fetch_req),
      .fetch_adrs   (fetch_adrs),
      .fetch_gnt    (fetch_gnt),
      .fetch_rvalid (fetch_rvalid),
      .ld_req       (ld_req),
      .ld_adrs      (ld_adrs),
      .ld_gnt       (ld_gnt),
      .ld_rvalid    (ld_rvalid),
      .st_req       (st_req),
      .st_adrs      (st_adrs),
      .st_wdata     (st_wdata),
      .st_gnt       (st_gnt),
      .mem_en       (mem_en),
      .mem_we       (mem_we),
      .mem_adrs     (mem_adrs),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .rdata        (rdata),
      .stall_fetch  (stall_fetch),
      .starve_cnt   (starve_cnt)
   );

   typedef struct {
      logic [1:0]    tag;
      logic [DW-1:0] data;
      int            due;
   } ret_t;

   ret_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   m_starve = 0;
   bit   lg_f, lg_l, lg_s;

   function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
      return ({21'd0, a} * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: cycle %0d got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous SRAM with RDL-cycle read latency, driven by the values the
   // DUT presented at the preceding falling edge.
   logic [DW-1:0] sram    [WORDS];
   bit            written [WORDS];
   logic [DW-1:0] rd_pipe [RDL];
   logic          cap_en = 1'b0, cap_we = 1'b0;
   logic [AW-1:0] cap_adrs = '0;
   logic [DW-1:0] cap_wdata = '0;

   assign mem_rdata = rd_pipe[RDL-1];

   always @(posedge clk) begin
      if (cap_en && cap_we) begin
         sram[cap_adrs]    <= cap_wdata;
         written[cap_adrs] <= 1'b1;
      end
      if (cap_en && !cap_we)
         rd_pipe[0] <= written[cap_adrs] ? sram[cap_adrs] : init_word(cap_adrs);
      else
         rd_pipe[0] <= 32'hA5A5_0BAD;
      for (int k = 1; k < RDL; k++) rd_pipe[k] <= rd_pipe[k-1];
   end

   // Reference model: arbitration rules, expected memory drive, starvation
   // count and a shadow copy of memory contents for expected read data.
   logic [DW-1:0] shadow    [WORDS];
   bit            shadow_wr [WORDS];

   always @(negedge clk) begin
      bit            ef, el, es;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      cap_en    = mem_en;
      cap_we    = mem_we;
      cap_adrs  = mem_adrs;
      cap_wdata = mem_wdata;
      if (cyc >= 1) begin
         ef = 0; el = 0; es = 0;
         if (resetn) begin
            if (fetch_req && m_starve == LIMIT) ef = 1;
            else if (st_req)                    es = 1;
            else if (ld_req)                    el = 1;
            else if (fetch_req)                 ef = 1;
         end
         ea = es ? st_adrs : (el ? ld_adrs : (ef ? fetch_adrs : '0));
         ed = es ? st_wdata : '0;
         check("grant", {fetch_gnt, ld_gnt, st_gnt}, {ef, el, es});
         check("mem_ctrl", {mem_en, mem_we}, {ef | el | es, es});
         check("mem_adrs", mem_adrs, ea);
         check("mem_wdata", mem_wdata, ed);
         check("stall_fetch", stall_fetch, fetch_req & ~ef);
         check("starve_cnt", starve_cnt, m_starve);
         if (ef || el)
            sb.push_back('{tag: ef ? TAG_FETCH : TAG_LD,
                           data: shadow_wr[ea] ? shadow[ea] : init_word(ea),
                           due: cyc + RDL});
         if (es) begin
            shadow[ea]    = ed;
            shadow_wr[ea] = 1'b1;
         end
         if (!resetn)                  m_starve = 0;
         else if (fetch_req && !ef)    m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
         else                          m_starve = 0;
         // A reset edge kills every read not yet at the output stage.
         if (!resetn)
            while (sb.size() > 0 && sb[$].due > cyc) void'(sb.pop_back());
         lg_f = ef; lg_l = el; lg_s = es;
      end
   end

   // Monitor: pops the oldest expected return when its cycle arrives.
   always begin
      @(negedge clk);
      #2;
      if (cyc >= 1) begin
         logic [1:0] exp_v;
         ret_t       e;
         exp_v = 2'b00;
         if (sb.size() > 0 && sb[0].due == cyc)
            exp_v = (sb[0].tag == TAG_FETCH) ? 2'b01 : 2'b10;
         check("rvalid", {ld_rvalid, fetch_rvalid}, exp_v);
         if (exp_v != 2'b00) begin
            e = sb.pop_front();
            check("rdata", rdata, e.data);
         end
      end
   end

   task automatic step(input bit f, input logic [AW-1:0] fa,
                       input bit l, input logic [AW-1:0] la,
                       input bit s, input logic [AW-1:0] sa, input logic [DW-1:0] sd);
      fetch_req = f; fetch_adrs = fa;
      ld_req    = l; ld_adrs    = la;
      st_req    = s; st_adrs    = sa; st_wdata = sd;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step(0, '0, 0, '0, 0, '0, '0);
   endtask

   initial begin
      bit            af, al, as_;
      logic [AW-1:0] rf, rl, rs;
      logic [DW-1:0] rd;
      resetn = 1'b0;
      idle(3);
      resetn = 1'b1;
      idle(1);

      // Fetch-only stream
      step(1, 11'h005, 0, '0, 0, '0, '0);
      step(1, 11'h006, 0, '0, 0, '0, '0);
      step(1, 11'h007, 0, '0, 0, '0, '0);
      idle(RDL + 1);

      // STORE and LOAD to the same address in one cycle
      step(0, '0, 1, 11'h010, 1, 11'h010, 32'hDEAD_BEEF);
      step(0, '0, 1, 11'h010, 0, '0, '0);
      idle(RDL + 1);

      // Fetch held against continuous STORE/LOAD pressure
      repeat (LIMIT + 1) step(1, 11'h100, 1, 11'h020, 1, 11'h021, 32'h0BAD_CAFE);
      step(0, '0, 1, 11'h020, 1, 11'h021, 32'h0BAD_CAFE);
      step(0, '0, 1, 11'h020, 0, '0, '0);
      idle(RDL + 1);

      // LOAD and fetch together
      step(1, 11'h040, 1, 11'h041, 0, '0, '0);
      step(1, 11'h040, 0, '0, 0, '0, '0);
      idle(RDL + 1);

      // Reset the cycle after a LOAD grant, requests held during reset
      step(0, '0, 1, 11'h050, 0, '0, '0);
      resetn = 1'b0;
      repeat (3) step(1, 11'h051, 1, 11'h052, 1, 11'h053, 32'h1111_2222);
      resetn = 1'b1;
      idle(RDL + 2);

      // LOAD withdrawn before it is ever granted
      step(0, '0, 1, 11'h061, 1, 11'h060, 32'hAAAA_0001);
      step(0, '0, 1, 11'h061, 1, 11'h062, 32'hAAAA_0002);
      step(0, '0, 0, '0, 1, 11'h063, 32'hAAAA_0003);
      idle(RDL + 1);

      // Randomised requesters obeying the hold-until-grant handshake
      af = 0; al = 0; as_ = 0; rf = '0; rl = '0; rs = '0; rd = '0;
      for (int c = 0; c < 3000; c++) begin
         if (af && lg_f) af = 0;
         if (al && lg_l) al = 0;
         if (as_ && lg_s) as_ = 0;
         if (af && $urandom_range(0, 9) == 0) af = 0;
         if (al && $urandom_range(0, 9) == 0) al = 0;
         if (as_ && $urandom_range(0, 9) == 0) as_ = 0;
         if (!af && $urandom_range(0, 2) != 0) begin af = 1; rf = AW'($urandom_range(0, 31)); end
         if (!al && $urandom_range(0, 2) != 0) begin al = 1; rl = AW'($urandom_range(0, 31)); end
         if (!as_ && $urandom_range(0, 3) != 0) begin
            as_ = 1; rs = AW'($urandom_range(0, 31)); rd = $urandom;
         end
         if ($urandom_range(0, 599) == 0) begin
            resetn = 1'b0;
            step(af, rf, al, rl, as_, rs, rd);
            step(af, rf, al, rl, as_, rs, rd);
            resetn = 1'b1;
            af = 0; al = 0; as_ = 0;
         end else begin
            step(af, rf, al, rl, as_, rs, rd);
         end
      end
      idle(RDL + 3);
      check("scoreboard_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port synchronous SRAM between the CPU's three memory requesters: instruction fetch read, LOAD read and STORE write. It grants at most one access per cycle using fixed priority with a fetch anti-starvation override. It returns read data with a per-requester valid strobe and drives a stall to the fetch stage. It sits between the CPU pipeline ports and the shared memory macro.

Parameters:
ADDR_W, 11, address width of all requesters and memory.
DATA_W, 32, data width.
STARVE_LIMIT, 4, number of consecutive denied fetch cycles after which fetch wins priority.
RD_LATENCY, 1, memory read latency in cycles (1..4).

Ports:
clk  input  1  clock
resetn  input  1  reset, synchronous, active-low
fetch_req  input  1  instruction read request
fetch_adrs  input  ADDR_W  instruction address
fetch_gnt  output  1  fetch accepted this cycle
fetch_rvalid  output  1  mem_rdata holds fetch data
ld_req  input  1  LOAD read request
ld_adrs  input  ADDR_W  LOAD address
ld_gnt  output  1  LOAD accepted this cycle
ld_rvalid  output  1  mem_rdata holds LOAD data
st_req  input  1  STORE write request
st_adrs  input  ADDR_W  STORE address
st_wdata  input  DATA_W  STORE data
st_gnt  output  1  STORE accepted this cycle
mem_en  output  1  memory enable
mem_we  output  1  memory write enable
mem_adrs  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data (valid RD_LATENCY cycles after a read is issued)
rdata  output  DATA_W  read data broadcast to both readers (pass-through of mem_rdata)
stall_fetch  output  1  fetch_req & ~fetch_gnt
starve_cnt  output  3  current starvation count (debug)

Behaviour:
- Handshake: a requester holds req, adrs and wdata stable until it sees gnt high at a rising edge. Transfer occurs on any cycle where req and gnt are both high. A requester may deassert req without a grant; no transfer occurs.
- Grant is combinational from the current reqs and the registered starve_cnt. At most one gnt is high per cycle. A gnt is never high without its req.
- Normal priority: STORE > LOAD > fetch.
- Override: when starve_cnt == STARVE_LIMIT and fetch_req is high, fetch wins over both others for that cycle.
- Memory drive:
  - mem_en = any gnt.
  - mem_we = st_gnt.
  - mem_adrs and mem_wdata come from the winner.
  - With no grant: mem_adrs = 0 and mem_wdata = 0.
- Starvation counter:
  - Increments when fetch_req & ~fetch_gnt.
  - Saturates at STARVE_LIMIT.
  - Clears to 0 on fetch_gnt or when fetch_req is low.
- Read return tracking: a RD_LATENCY-deep shift register carries a 2-bit tag per cycle (NONE, FETCH, LD), loaded from the granted read.
  - fetch_rvalid and ld_rvalid are decoded from the tag at the output stage. They are registered and never both high.
  - rdata = mem_rdata, meaningful only while a valid is high.
  - Back-to-back reads are fully pipelined: one grant per cycle, with returns in issue order.
- Same-address hazard: if STORE and LOAD request the same address in the same cycle, STORE is granted first. The LOAD is granted on a later cycle and returns the newly written data.
- Reset (resetn low at an edge):
  - Tag pipe cleared, starve_cnt cleared.
  - fetch_rvalid and ld_rvalid go to 0 and stay 0 for the full RD_LATENCY window; reads in flight at reset are dropped silently.
  - The combinational outputs (gnt, mem_*) are forced to 0 while resetn is low.
- No internal queuing: the block holds no request state beyond starve_cnt and the tag pipe.

Decomposition:
- Shared package cpu_mem_pkg holds:
  - requester tag constants TAG_NONE=2'b00, TAG_FETCH=2'b01, TAG_LD=2'b10;
  - ADDR_W and DATA_W defaults, shared with the cpu and memory blocks.
- One natural sub-module, rd_tag_pipe: a parameterised shift register for the tags with synchronous clear.

Test Plan:
1. Fetch only, adrs 0x005, 0x006, 0x007 on consecutive cycles -> fetch_gnt high each cycle; fetch_rvalid high 1 cycle later each time; rdata equals the preloaded words in order.
2. STORE 0x010 <= 0xDEADBEEF and LOAD 0x010 requested in the same cycle -> st_gnt cycle N, ld_gnt cycle N+1, ld_rvalid cycle N+2 with rdata = 0xDEADBEEF.
3. Fetch held with STORE/LOAD continuously requesting -> fetch denied 4 cycles (starve_cnt 1..4, stall_fetch high); fetch_gnt on cycle 5, starve_cnt back to 0.
4. LOAD and fetch simultaneous, no STORE, starve_cnt = 0 -> ld_gnt first, fetch_gnt next cycle, starve_cnt peaks at 1; rvalids arrive in order LD then FETCH.
5. Reset asserted the cycle after a LOAD grant (RD_LATENCY = 2) -> ld_rvalid never asserts; all gnt and mem_en are 0 during reset; starve_cnt = 0.
6. ld_req raised then dropped before any grant while STORE is active -> no ld_gnt, no ld_rvalid, and no memory read is issued to the LOAD address.
